// File: rtl/decode_stage_hz_if.sv
// D-stage inputs and E-stage outputs of decode_stage_hz, bundled as one port.
// The slave modport is the decode stage; master is the surrounding pipeline.
interface decode_stage_hz_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int RW = $clog2(NREG);

    logic [31:0]      instr_d;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  pc_plus4_d;
    logic             valid_d;
    logic             reg_write_w;
    logic [RW-1:0]    rd_w;
    logic [XLEN-1:0]  result_w;
    logic             flush_e;
    logic             hold_e;

    logic             load_use_stall;
    logic             valid_e;
    logic             reg_write_e;
    logic             mem_write_e;
    logic             mem_read_e;
    logic             alu_src_e;
    logic             branch_e;
    logic             jump_e;
    logic             illegal_e;
    logic [1:0]       result_src_e;
    logic [3:0]       alu_control_e;
    logic [2:0]       funct3_e;
    logic [XLEN-1:0]  rd1_e;
    logic [XLEN-1:0]  rd2_e;
    logic [XLEN-1:0]  imm_ext_e;
    logic [XLEN-1:0]  pc_e;
    logic [XLEN-1:0]  pc_plus4_e;
    logic [RW-1:0]    rd_e;
    logic [RW-1:0]    rs1_e;
    logic [RW-1:0]    rs2_e;

    modport slave (
        input  instr_d, pc_d, pc_plus4_d, valid_d, reg_write_w, rd_w, result_w,
               flush_e, hold_e,
        output load_use_stall, valid_e, reg_write_e, mem_write_e, mem_read_e,
               alu_src_e, branch_e, jump_e, illegal_e, result_src_e, alu_control_e,
               funct3_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rd_e, rs1_e, rs2_e
    );

    modport master (
        output instr_d, pc_d, pc_plus4_d, valid_d, reg_write_w, rd_w, result_w,
               flush_e, hold_e,
        input  load_use_stall, valid_e, reg_write_e, mem_write_e, mem_read_e,
               alu_src_e, branch_e, jump_e, illegal_e, result_src_e, alu_control_e,
               funct3_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rd_e, rs1_e, rs2_e
    );
endinterface

// File: rtl/decode_stage_hz.sv
// RV32I/RV64I decode stage: control decode, immediates, register file with
// write-through, load-use detection and a flush/hold-capable D->E register.
module decode_stage_hz #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic               clk,
    input  logic               rst,
    decode_stage_hz_if.slave   bus
);
    localparam int RW = $clog2(NREG);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
        ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_write;
        logic             mem_read;
        logic             alu_src;
        logic             branch;
        logic             jump;
        logic             illegal;
        logic [1:0]       result_src;
        alu_op_t          alu_control;
        logic [2:0]       funct3;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc_plus4;
        logic [RW-1:0]    rd;
        logic [RW-1:0]    rs1;
        logic [RW-1:0]    rs2;
    } e_reg_t;

    logic [XLEN-1:0] regs [NREG];
    e_reg_t          dec;
    e_reg_t          e_q;
    imm_t            imm_sel;
    logic [31:0]     imm32;
    logic            rs1_used;
    logic            rs2_used;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RW-1:0]   rs1_d;
    logic [RW-1:0]   rs2_d;
    logic [RW-1:0]   rd_d;
    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;

    assign opcode = bus.instr_d[6:0];
    assign funct3 = bus.instr_d[14:12];
    assign rd_d   = bus.instr_d[7 +: RW];
    assign rs1_d  = bus.instr_d[15 +: RW];
    assign rs2_d  = bus.instr_d[20 +: RW];

    // NOTE: the register file is reset like any other state here because a
    // mid-stream rst must wipe architectural registers, not just the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.reg_write_w && bus.rd_w != '0) begin
            // NOTE: non-blocking assignment keeps every register updating from
            // pre-edge values, regardless of process ordering.
            regs[bus.rd_w] <= bus.result_w;
        end
    end

    // Same-cycle writeback is bypassed so W and D can share a cycle.
    assign rd1_d = (rs1_d == '0) ? '0 :
                   (bus.reg_write_w && bus.rd_w == rs1_d) ? bus.result_w : regs[rs1_d];
    assign rd2_d = (rs2_d == '0) ? '0 :
                   (bus.reg_write_w && bus.rd_w == rs2_d) ? bus.result_w : regs[rs2_d];

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path through
        // the case statements can leave a value held, which would infer a latch.
        dec             = '0;
        imm_sel         = IMM_I;
        rs1_used        = 1'b1;
        rs2_used        = 1'b0;
        dec.valid       = 1'b1;
        dec.alu_control = ALU_ADD;
        unique case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                rs2_used      = 1'b1;
                unique case (funct3)
                    3'd0: dec.alu_control = bus.instr_d[30] ? ALU_SUB : ALU_ADD;
                    3'd1: dec.alu_control = ALU_SLL;
                    3'd2: dec.alu_control = ALU_SLT;
                    3'd3: dec.alu_control = ALU_SLTU;
                    3'd4: dec.alu_control = ALU_XOR;
                    3'd5: dec.alu_control = bus.instr_d[30] ? ALU_SRA : ALU_SRL;
                    3'd6: dec.alu_control = ALU_OR;
                    default: dec.alu_control = ALU_AND;
                endcase
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                unique case (funct3)
                    3'd0: dec.alu_control = ALU_ADD;
                    3'd1: dec.alu_control = ALU_SLL;
                    3'd2: dec.alu_control = ALU_SLT;
                    3'd3: dec.alu_control = ALU_SLTU;
                    3'd4: dec.alu_control = ALU_XOR;
                    3'd5: dec.alu_control = bus.instr_d[30] ? ALU_SRA : ALU_SRL;
                    3'd6: dec.alu_control = ALU_OR;
                    default: dec.alu_control = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = IMM_S;
                rs2_used      = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
                imm_sel         = IMM_B;
                rs2_used        = 1'b1;
            end
            OP_JAL: begin
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                imm_sel        = IMM_J;
                rs1_used       = 1'b0;
            end
            OP_LUI: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_PASS_B;
                imm_sel         = IMM_U;
                rs1_used        = 1'b0;
            end
            default: dec.illegal = 1'b1;
        endcase

        unique case (imm_sel)
            IMM_S:   imm32 = {{20{bus.instr_d[31]}}, bus.instr_d[31:25], bus.instr_d[11:7]};
            IMM_B:   imm32 = {{20{bus.instr_d[31]}}, bus.instr_d[7], bus.instr_d[30:25],
                              bus.instr_d[11:8], 1'b0};
            IMM_U:   imm32 = {bus.instr_d[31:12], 12'b0};
            IMM_J:   imm32 = {{12{bus.instr_d[31]}}, bus.instr_d[19:12], bus.instr_d[20],
                              bus.instr_d[30:21], 1'b0};
            default: imm32 = {{20{bus.instr_d[31]}}, bus.instr_d[31:20]};
        endcase

        dec.imm      = XLEN'(signed'(imm32));
        dec.funct3   = funct3;
        dec.rd1      = rd1_d;
        dec.rd2      = rd2_d;
        dec.pc       = bus.pc_d;
        dec.pc_plus4 = bus.pc_plus4_d;
        dec.rd       = rd_d;
        dec.rs1      = rs1_d;
        dec.rs2      = rs2_d;
    end

    assign bus.load_use_stall = bus.valid_d & e_q.mem_read & e_q.valid & (e_q.rd != '0) &
                                ((rs1_used & (rs1_d == e_q.rd)) | (rs2_used & (rs2_d == e_q.rd)));

    // Bubbles are all-zero; an invalid D instruction also enters as a bubble.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_e) begin
            e_q <= '0;
        end else if (!bus.hold_e) begin
            if (bus.load_use_stall || !bus.valid_d) e_q <= '0;
            else                                    e_q <= dec;
        end
    end

    assign bus.valid_e       = e_q.valid;
    assign bus.reg_write_e   = e_q.reg_write;
    assign bus.mem_write_e   = e_q.mem_write;
    assign bus.mem_read_e    = e_q.mem_read;
    assign bus.alu_src_e     = e_q.alu_src;
    assign bus.branch_e      = e_q.branch;
    assign bus.jump_e        = e_q.jump;
    assign bus.illegal_e     = e_q.illegal;
    assign bus.result_src_e  = e_q.result_src;
    assign bus.alu_control_e = e_q.alu_control;
    assign bus.funct3_e      = e_q.funct3;
    assign bus.rd1_e         = e_q.rd1;
    assign bus.rd2_e         = e_q.rd2;
    assign bus.imm_ext_e     = e_q.imm;
    assign bus.pc_e          = e_q.pc;
    assign bus.pc_plus4_e    = e_q.pc_plus4;
    assign bus.rd_e          = e_q.rd;
    assign bus.rs1_e         = e_q.rs1;
    assign bus.rs2_e         = e_q.rs2;
endmodule
